// File: rtl/image_loader.sv
// Receives a binarised image word-by-word while the control FSM is in LOAD,
// packs BUS_W pixels per accepted word into a flat buffer and pulses load_done.
module image_loader #(
  parameter int          IMG_W     = 28,
  parameter int          IMG_H     = 28,
  parameter int          BUS_W     = 8,
  parameter logic [2:0]  LOAD_CODE = 3'b001,
  localparam int         NPIX      = IMG_W * IMG_H,
  localparam int         NWORDS    = (NPIX + BUS_W - 1) / BUS_W,
  localparam int         CNT_W     = $clog2(NWORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       fsm_state,
  input  logic [BUS_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             load_done,
  output logic [CNT_W-1:0] word_cnt,
  output logic [NPIX-1:0]  pixels
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             load_done_q, load_done_d;
  logic [NPIX-1:0]  pixels_q, pixels_d;
  logic [NWORDS-1:0] wr_word;
  logic             is_load;
  logic             accept;

  assign is_load = (fsm_state == LOAD_CODE);
  // Leaving LOAD takes priority over a word presented on the same edge.
  assign accept  = (state_q == RECV) && is_load && in_valid;

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    load_done_d = 1'b0;
    case (state_q)
      IDLE: if (is_load) begin
        state_d    = RECV;
        word_cnt_d = '0;
      end
      RECV: begin
        if (!is_load) begin
          state_d = IDLE;
        end else if (in_valid) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == LAST) begin
            state_d     = DONE;
            load_done_d = 1'b1;
          end
        end
      end
      DONE: if (!is_load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One write enable per word slot; bits beyond NPIX in the last word are dropped.
  for (genvar k = 0; k < NWORDS; k++) begin : g_word
    assign wr_word[k] = accept && (word_cnt_q == CNT_W'(k));
    for (genvar i = 0; i < BUS_W; i++) begin : g_bit
      if (k * BUS_W + i < NPIX) begin : g_keep
        assign pixels_d[k*BUS_W+i] = wr_word[k] ? in_data[i] : pixels_q[k*BUS_W+i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      load_done_q <= 1'b0;
      pixels_q    <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      load_done_q <= load_done_d;
      pixels_q    <= pixels_d;
    end
  end

  assign in_ready  = (state_q == RECV);
  assign load_done = load_done_q;
  assign word_cnt  = word_cnt_q;
  assign pixels    = pixels_q;

endmodule
